uart_hex_reporter: RTL and testbench
====================================

UART_HEX_REPORTER -- requirements
Module: uart_hex_reporter

Interface
REQ-001 SHALL have parameter CLK_FRE, default 50, meaning the clock frequency in MHz, passed to the TX sub-module.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, meaning the UART bit rate, passed to the TX sub-module.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock, 50 MHz.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port report_valid, input, 1 bit: a report request is present.
REQ-006 SHALL have port report_ready, output, 1 bit: the block can accept a request.
REQ-007 SHALL have port report_tag, input, 2 bits: the register index r0-r3.
REQ-008 SHALL have port report_data, input, 8 bits: the register value to report.
REQ-009 SHALL have port busy, output, 1 bit: a report is being serialized.
REQ-010 SHALL have port report_count, output, 8 bits: the number of completed reports.
REQ-011 SHALL have port uart_tx, output, 1 bit: the serial line, idle high.

Function
REQ-012 SHALL accept a request only on a cycle where report_valid and report_ready are both 1.
- report_tag and report_data are captured on that same edge.
REQ-013 SHALL tolerate source changes after acceptance.
- report_valid, report_tag and report_data may change after the accept edge without affecting the frame in progress.
REQ-014 SHALL emit exactly 7 bytes per accepted request, in this order:
- 0x52 'R'
- 0x30+tag
- 0x3D '='
- high-nibble hex
- low-nibble hex
- 0x0D
- 0x0A
REQ-015 SHALL encode hex as uppercase ASCII:
- nibbles 0-9 map to 0x30-0x39;
- nibbles A-F map to 0x41-0x46.
REQ-016 SHALL implement an FSM with states IDLE, SEND and DONE.
REQ-017 SHALL take these FSM transitions:
- IDLE goes to SEND on accept.
- SEND stays in SEND until the byte-7 handshake, then goes to DONE.
- DONE goes to IDLE unconditionally after one cycle.
REQ-018 SHALL drive report_ready=1 only in IDLE, and busy equal to NOT report_ready.
REQ-019 SHALL drive the TX handshake in SEND as follows:
- tx_data_valid is held at 1 while in SEND;
- tx_data is the byte selected by a 3-bit index (0-6);
- the index advances only on a cycle where tx_data_valid and tx_data_ready are both 1.
REQ-020 SHALL assert tx_data_valid for the first byte on the cycle after the accept edge.
REQ-021 SHALL never present a byte that does not belong to the captured frame.
- The index resets to 0 on entry to SEND.
- No byte is skipped or repeated.
REQ-022 SHALL increment report_count by 1 in DONE, with modulo-256 wrap (0xFF goes to 0x00).
REQ-023 SHALL ignore report_valid while not in IDLE; requests are neither queued nor counted.
REQ-024 SHALL allow back-to-back frames: a request that is valid and waiting is accepted on the first IDLE cycle after DONE.

Reset
REQ-025 SHALL, on rst_n=0, asynchronously force:
- the FSM to IDLE;
- the index to 0;
- tx_data_valid=0;
- report_count=0x00;
- report_ready=1;
- busy=0;
- uart_tx=1.
REQ-026 SHALL, if reset is asserted mid-frame, abort the frame with no resumption.
- The first frame after reset release starts again at 'R'.
REQ-027 SHALL accept a request on the first clock edge after rst_n deasserts.

Structure
REQ-028 SHALL keep the FSM state encodings and the ASCII constants ('R', '=', '0', 'A', CR, LF) in a shared include header used by the ISA blocks.
REQ-029 SHALL instantiate exactly one sub-module, the team's existing uart_tx, with the ports:
- clk, rst_n;
- tx_data[7:0], tx_data_valid, tx_data_ready;
- tx_pin, which drives uart_tx.
REQ-030 SHALL keep nibble-to-ASCII conversion as local combinational logic, with no extra module.

Verification
REQ-031 Single report: tag=2, data=0x3C -> uart_tx carries 0x52 0x32 0x3D 0x33 0x43 0x0D 0x0A, and report_count goes 0 to 1.
REQ-032 Hex extremes: data=0x00 gives 0x30 0x30; data=0xFF gives 0x46 0x46; data=0xA9 gives 0x41 0x39.
REQ-033 Busy drop: a second request (tag=1, 0x55) held valid during byte 3 -> not accepted; it is accepted immediately after DONE and sent as the second frame.
REQ-034 Source change: after accepting tag=0, data=0x12, the source changes to 0x99 -> the frame still reads "R0=12\r\n".
REQ-035 Mid-frame reset: rst_n pulled low during byte 4 -> uart_tx is high and report_count is 0; a new request after release produces a complete frame starting with 0x52.
REQ-036 Wrap: 256 consecutive reports -> report_count returns to 0x00, and every frame decodes correctly at 115200 baud.

Source files
------------

// File: rtl/uart_hex_reporter_pkg.sv
// Shared definitions for the hex reporter: FSM encodings, ASCII constants and
// frame geometry used by the reporter top and its serializer.
package uart_hex_reporter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } rpt_state_e;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    localparam logic [7:0] ASCII_R  = 8'h52;
    localparam logic [7:0] ASCII_EQ = 8'h3D;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_A  = 8'h41;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // Index of the final byte in a report frame ("R", tag, "=", hi, lo, CR, LF).
    localparam logic [2:0] LAST_IDX = 3'd6;

endpackage

// File: rtl/uart_hex_reporter_tx.sv
// 8N1 UART serializer with a valid/ready byte interface; ready only while idle.
// Bit timing comes from a down-counter reloaded with the clocks-per-bit value.
//
// state    | meaning
// TX_IDLE  | line high, ready for a byte
// TX_START | driving the start bit
// TX_DATA  | shifting out 8 data bits, LSB first
// TX_STOP  | driving the stop bit
module uart_tx
    import uart_hex_reporter_pkg::*;
#(
    parameter int CLK_FRE   = 50,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_data_valid,
    output logic       tx_data_ready,
    output logic       tx_pin
);

    localparam int CYCLE = (CLK_FRE * 1000000) / BAUD_RATE;
    localparam int CNT_W = (CYCLE > 1) ? $clog2(CYCLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CYCLE - 1);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             pin_q, pin_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            pin_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            pin_q   <= pin_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pin_d   = pin_q;
        case (state_q)
            TX_IDLE: begin
                pin_d = 1'b1;
                if (tx_data_valid) begin
                    shift_d = tx_data;
                    pin_d   = 1'b0;
                    cnt_d   = CNT_LOAD;
                    state_d = TX_START;
                end
            end
            TX_START: begin
                if (cnt_q == '0) begin
                    pin_d   = shift_q[0];
                    bit_d   = 3'd0;
                    cnt_d   = CNT_LOAD;
                    state_d = TX_DATA;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            TX_DATA: begin
                if (cnt_q == '0) begin
                    cnt_d = CNT_LOAD;
                    if (bit_q == 3'd7) begin
                        pin_d   = 1'b1;
                        state_d = TX_STOP;
                    end else begin
                        // shift_q[0] always holds the bit currently on the line
                        shift_d = {1'b0, shift_q[7:1]};
                        pin_d   = shift_q[1];
                        bit_d   = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            TX_STOP: begin
                if (cnt_q == '0) begin
                    state_d = TX_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = TX_IDLE;
                pin_d   = 1'b1;
            end
        endcase
    end

    assign tx_data_ready = (state_q == TX_IDLE);
    assign tx_pin        = pin_q;

endmodule

// File: rtl/uart_hex_reporter.sv
// Formats a tagged register value as "Rn=HH\r\n" and streams it over UART.
// One request is captured per frame; requests arriving while busy are dropped.
//
// state   | meaning
// ST_IDLE | ready for a request
// ST_SEND | feeding the 7 frame bytes to the serializer
// ST_DONE | frame handed off, bump the report counter
module uart_hex_reporter
    import uart_hex_reporter_pkg::*;
#(
    parameter int CLK_FRE   = 50,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       report_valid,
    output logic       report_ready,
    input  logic [1:0] report_tag,
    input  logic [7:0] report_data,
    output logic       busy,
    output logic [7:0] report_count,
    output logic       uart_tx
);

    rpt_state_e state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [1:0] tag_q, tag_d;
    logic [7:0] data_q, data_d;
    logic [7:0] count_q, count_d;

    logic [7:0] tx_data;
    logic       tx_data_valid;
    logic       tx_data_ready;
    logic [7:0] hi_ascii;
    logic [7:0] lo_ascii;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            tag_q   <= '0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tag_d   = tag_q;
        data_d  = data_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (report_valid) begin
                    tag_d   = report_tag;
                    data_d  = report_data;
                    idx_d   = 3'd0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (tx_data_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                count_d = count_q + 8'd1;
                idx_d   = 3'd0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = 3'd0;
            end
        endcase
    end

    // Nibble to uppercase hex ASCII: 0-9 from '0', A-F from 'A'.
    always_comb begin
        hi_ascii = (data_q[7:4] < 4'd10) ? (ASCII_0 + {4'd0, data_q[7:4]})
                                         : (ASCII_A + {4'd0, data_q[7:4]} - 8'd10);
        lo_ascii = (data_q[3:0] < 4'd10) ? (ASCII_0 + {4'd0, data_q[3:0]})
                                         : (ASCII_A + {4'd0, data_q[3:0]} - 8'd10);
    end

    always_comb begin
        tx_data = ASCII_R;
        case (idx_q)
            3'd0:    tx_data = ASCII_R;
            3'd1:    tx_data = ASCII_0 + {6'd0, tag_q};
            3'd2:    tx_data = ASCII_EQ;
            3'd3:    tx_data = hi_ascii;
            3'd4:    tx_data = lo_ascii;
            3'd5:    tx_data = ASCII_CR;
            3'd6:    tx_data = ASCII_LF;
            default: tx_data = ASCII_R;
        endcase
    end

    assign tx_data_valid = (state_q == ST_SEND);
    assign report_ready  = (state_q == ST_IDLE);
    assign busy          = ~report_ready;
    assign report_count  = count_q;

    uart_tx #(
        .CLK_FRE  (CLK_FRE),
        .BAUD_RATE(BAUD_RATE)
    ) u_uart_tx (
        .clk          (clk),
        .rst_n        (rst_n),
        .tx_data      (tx_data),
        .tx_data_valid(tx_data_valid),
        .tx_data_ready(tx_data_ready),
        .tx_pin       (uart_tx)
    );

endmodule

// File: tb/tb_uart_hex_reporter.sv
// Bench for uart_hex_reporter: a line decoder rebuilds bytes from uart_tx and
// each scenario compares whole frames against a string-level reference.
module tb_uart_hex_reporter;

    localparam int CLK_FRE   = 3;
    localparam int BAUD_RATE = 1000000;
    localparam int BIT_CLKS  = (CLK_FRE * 1000000) / BAUD_RATE;

    logic       clk;
    logic       rst_n;
    logic       report_valid;
    logic       report_ready;
    logic [1:0] report_tag;
    logic [7:0] report_data;
    logic       busy;
    logic [7:0] report_count;
    logic       uart_tx;

    int checks = 0;
    int errors = 0;
    int frame_err = 0;
    int rst_seen = 0;
    logic [7:0] rx_q[$];

    uart_hex_reporter #(
        .CLK_FRE  (CLK_FRE),
        .BAUD_RATE(BAUD_RATE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .report_valid(report_valid),
        .report_ready(report_ready),
        .report_tag  (report_tag),
        .report_data (report_data),
        .busy        (busy),
        .report_count(report_count),
        .uart_tx     (uart_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge rst_n);
            rst_seen++;
        end
    end

    // Line decoder: sample mid-bit, drop any byte that a reset cut through.
    initial begin
        logic [7:0] b;
        logic       stop_bit;
        int         r;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && uart_tx === 1'b0) begin
                r = rst_seen;
                @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT_CLKS) @(negedge clk);
                    b[i] = uart_tx;
                end
                repeat (BIT_CLKS) @(negedge clk);
                stop_bit = uart_tx;
                if (r == rst_seen) begin
                    if (stop_bit !== 1'b1) frame_err++;
                    rx_q.push_back(b);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        int v;
        v = (n < 10) ? (48 + int'(n)) : (55 + int'(n));
        return 8'(v);
    endfunction

    function automatic logic [55:0] ref_frame(input logic [1:0] tag, input logic [7:0] d);
        return {8'h52, 8'(48 + int'(tag)), 8'h3D, hex_char(d[7:4]), hex_char(d[3:0]),
                8'h0D, 8'h0A};
    endfunction

    task automatic send_request(input logic [1:0] tag, input logic [7:0] d);
        int t = 0;
        @(negedge clk);
        while (report_ready !== 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        report_valid = 1'b1;
        report_tag   = tag;
        report_data  = d;
        @(posedge clk);
        #1;
        report_valid = 1'b0;
    endtask

    task automatic collect_frame(output logic [55:0] got);
        int t = 0;
        while (rx_q.size() < 7 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (rx_q.size() < 7) begin
            got = 'x;
            rx_q.delete();
        end else begin
            got = '0;
            for (int i = 0; i < 7; i++) got = {got[47:0], rx_q.pop_front()};
        end
    endtask

    task automatic wait_bytes(input int n);
        int t = 0;
        while (rx_q.size() < n && t < 2000) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        report_valid = 1'b0;
        report_tag = '0;
        report_data = '0;
        repeat (5) @(negedge clk);
        checks++;
        if (report_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b, required 1", report_ready);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b, required 0", busy);
        end
        checks++;
        if (uart_tx !== 1'b1) begin
            errors++;
            $display("FAIL reset_uart_tx: got %b, required 1", uart_tx);
        end
        checks++;
        if (report_count !== 8'h00) begin
            errors++;
            $display("FAIL reset_count: got %h, required 00", report_count);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_single();
        logic [55:0] got;
        send_request(2'd2, 8'h3C);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL single_accept_busy: got %b, required 1", busy);
        end
        @(negedge clk);
        checks++;
        if (uart_tx !== 1'b1) begin
            errors++;
            $display("FAIL single_line_before_handshake: got %b, required 1", uart_tx);
        end
        @(negedge clk);
        checks++;
        if (uart_tx !== 1'b0) begin
            errors++;
            $display("FAIL single_start_bit_latency: got %b, required 0", uart_tx);
        end
        collect_frame(got);
        checks++;
        if (got !== 56'h52323D33430D0A) begin
            errors++;
            $display("FAIL single_frame: got %h, required 52323d33430d0a", got);
        end
        checks++;
        if (report_count !== 8'd1) begin
            errors++;
            $display("FAIL single_count: got %h, required 01", report_count);
        end
    endtask

    task automatic test_hex_extremes();
        logic [55:0] got;
        logic [7:0]  vals[7];
        logic [1:0]  tag;
        vals[0] = 8'h00;
        vals[1] = 8'hFF;
        vals[2] = 8'hA9;
        for (int i = 3; i < 7; i++) vals[i] = 8'($urandom);
        for (int i = 0; i < 7; i++) begin
            tag = 2'($urandom);
            send_request(tag, vals[i]);
            collect_frame(got);
            checks++;
            if (got !== ref_frame(tag, vals[i])) begin
                errors++;
                $display("FAIL hex_frame[%0d] tag=%0d data=%h: got %h, required %h",
                         i, tag, vals[i], got, ref_frame(tag, vals[i]));
            end
        end
    endtask

    task automatic test_busy_drop();
        logic [55:0] got;
        logic [1:0]  tag0;
        logic [7:0]  d0;
        logic [7:0]  base;
        int          t;
        tag0 = 2'($urandom);
        d0   = 8'($urandom);
        base = report_count;
        send_request(tag0, d0);
        report_valid = 1'b1;
        report_tag   = 2'd1;
        report_data  = 8'h55;
        wait_bytes(2);
        repeat (10) @(negedge clk);
        checks++;
        if (report_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_drop_during_byte3: ready=%b busy=%b, required ready=0 busy=1",
                     report_ready, busy);
        end
        t = 0;
        while (report_ready !== 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (report_count !== 8'(base + 1)) begin
            errors++;
            $display("FAIL busy_drop_count_after_first: got %h, required %h",
                     report_count, 8'(base + 1));
        end
        @(posedge clk);
        #1;
        report_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_drop_back_to_back_accept: got busy=%b, required 1", busy);
        end
        collect_frame(got);
        checks++;
        if (got !== ref_frame(tag0, d0)) begin
            errors++;
            $display("FAIL busy_drop_frame1: got %h, required %h", got, ref_frame(tag0, d0));
        end
        collect_frame(got);
        checks++;
        if (got !== 56'h52313D35350D0A) begin
            errors++;
            $display("FAIL busy_drop_frame2: got %h, required 52313d35350d0a", got);
        end
        checks++;
        if (report_count !== 8'(base + 2)) begin
            errors++;
            $display("FAIL busy_drop_count: got %h, required %h", report_count, 8'(base + 2));
        end
    endtask

    task automatic test_source_change();
        logic [55:0] got;
        send_request(2'd0, 8'h12);
        report_data = 8'h99;
        report_tag  = 2'd3;
        collect_frame(got);
        checks++;
        if (got !== 56'h52303D31320D0A) begin
            errors++;
            $display("FAIL source_change_frame: got %h, required 52303d31320d0a", got);
        end
    endtask

    task automatic test_mid_reset();
        logic [55:0] got;
        logic [1:0]  tag;
        logic [7:0]  d;
        send_request(2'($urandom), 8'($urandom));
        wait_bytes(3);
        repeat (12) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (uart_tx !== 1'b1 || report_count !== 8'h00 || report_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_state: uart_tx=%b count=%h ready=%b busy=%b, required 1 00 1 0",
                     uart_tx, report_count, report_ready, busy);
        end
        repeat (40) @(negedge clk);
        rx_q.delete();
        tag = 2'($urandom);
        d   = 8'($urandom);
        report_valid = 1'b1;
        report_tag   = tag;
        report_data  = d;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        report_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_first_edge_accept: got busy=%b, required 1", busy);
        end
        collect_frame(got);
        checks++;
        if (got !== ref_frame(tag, d)) begin
            errors++;
            $display("FAIL mid_reset_new_frame: got %h, required %h", got, ref_frame(tag, d));
        end
        repeat (60) @(negedge clk);
        checks++;
        if (rx_q.size() != 0 || report_count !== 8'd1) begin
            errors++;
            $display("FAIL mid_reset_no_resume: extra bytes=%0d count=%h, required 0 and 01",
                     rx_q.size(), report_count);
        end
    endtask

    task automatic test_wrap();
        logic [55:0] got;
        logic [1:0]  tag;
        logic [7:0]  d;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rx_q.delete();
        for (int i = 0; i < 256; i++) begin
            tag = 2'($urandom);
            d   = 8'($urandom);
            send_request(tag, d);
            collect_frame(got);
            checks++;
            if (got !== ref_frame(tag, d)) begin
                errors++;
                $display("FAIL wrap_frame[%0d]: got %h, required %h", i, got, ref_frame(tag, d));
            end
            if (i == 254) begin
                checks++;
                if (report_count !== 8'hFF) begin
                    errors++;
                    $display("FAIL wrap_count_255: got %h, required ff", report_count);
                end
            end
        end
        checks++;
        if (report_count !== 8'h00) begin
            errors++;
            $display("FAIL wrap_count_256: got %h, required 00", report_count);
        end
    endtask

    task automatic test_framing();
        checks++;
        if (frame_err != 0) begin
            errors++;
            $display("FAIL stop_bits: got %0d bad stop bits, required 0", frame_err);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_hex_extremes();
        test_busy_drop();
        test_source_change();
        test_mid_reset();
        test_wrap();
        test_framing();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
